// File: rtl/hazard_pkg.sv
// Shared types and default widths for the pipeline hazard controller and its helpers.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_t;

  localparam int XZR_IDX          = 31;
  localparam int REG_W_DEF        = 5;
  localparam int MEM_WAIT_MAX_DEF = 15;
  localparam int CNT_W_DEF        = 32;
  localparam int WAIT_W           = 8;

endpackage

// File: rtl/hazard_lu_detect.sv
// Combinational load-use hazard compare between the load in ID/EX and the sources in IF/ID.
module hazard_lu_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  output logic             lu
);

  localparam logic [REG_W-1:0] XZR = REG_W'(XZR_IDX);

  // A load targeting the zero register produces nothing a consumer could wait on.
  always_comb begin
    lu = ex_mem_read && (ex_rd != XZR) &&
         ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use stalls, branch flushes, dmem freeze with watchdog.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W        = REG_W_DEF,
  parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             br_taken_ex,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

  hz_state_t         state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              lu;

  hazard_lu_detect #(.REG_W(REG_W)) u_lu_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .lu          (lu)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // The counter holds the number of busy cycles already spent; one more busy cycle past the limit halts.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (dmem_busy) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_busy) begin
          if (wait_cnt == WAIT_LIMIT) begin
            state_nxt = HALT;
          end else begin
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          end
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // MEM_WAIT shares RUN's decode so a release cycle services a held branch or load-use at once.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    mem_timeout  = 1'b0;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (state)
        RUN, MEM_WAIT: begin
          if (dmem_busy) begin
            pipe_freeze = 1'b1;
          end else if (br_taken_ex) begin
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (lu) begin
            id_ex_bubble = 1'b1;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
          end
        end
        HALT: begin
          pipe_freeze = 1'b1;
          mem_timeout = 1'b1;
        end
        default: begin
          pipe_freeze = 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (if_id_flush) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, watchdog/perf sequences, then random traffic vs a streak-count model.
module tb_pipe_hazard_ctrl;
  import hazard_pkg::*;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs2, ex_mem_read, br_taken_ex, dmem_busy;
  logic        pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout;
  logic [31:0] stall_cycles, flush_count;

  int nCompared = 0;
  int nMismatched = 0;

  // Reference model state: consecutive busy cycles seen, halted flag, perf tallies.
  int          busyStreak = 0;
  bit          halted = 1'b0;
  logic [31:0] mStall = '0;
  logic [31:0] mFlush = '0;

  // Output bundle order: {pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout}
  localparam logic [5:0] O_RST   = 6'b001100;
  localparam logic [5:0] O_RUN   = 6'b110000;
  localparam logic [5:0] O_LU    = 6'b000100;
  localparam logic [5:0] O_BR    = 6'b111100;
  localparam logic [5:0] O_FRZ   = 6'b000010;
  localparam logic [5:0] O_HALT  = 6'b000011;

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses;
    logic       mread;
    logic [4:0] rd;
    logic       br;
    logic       busy;
    logic [5:0] exp;
  } vec_t;

  vec_t table_q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(5), .MEM_WAIT_MAX(MAX), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs2  (id_uses_rs2),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .br_taken_ex  (br_taken_ex),
    .dmem_busy    (dmem_busy),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .pipe_freeze  (pipe_freeze),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  function automatic vec_t mkVec(string name, logic r, logic [4:0] rs1, logic [4:0] rs2, logic uses,
                                 logic mread, logic [4:0] rd, logic br, logic busy, logic [5:0] exp);
    vec_t v;
    v.name = name; v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.uses = uses;
    v.mread = mread; v.rd = rd; v.br = br; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  // Model outputs straight from the priority rules, using the halted flag instead of any FSM state.
  function automatic logic [5:0] modelOut();
    bit hazard;
    hazard = ex_mem_read && (ex_rd != 5'd31) &&
             ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    if (rst)         return O_RST;
    if (halted)      return O_HALT;
    if (dmem_busy)   return O_FRZ;
    if (br_taken_ex) return O_BR;
    if (hazard)      return O_LU;
    return O_RUN;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs2 = v.uses;
    ex_mem_read = v.mread; ex_rd = v.rd; br_taken_ex = v.br; dmem_busy = v.busy;
  endtask

  task automatic checkOutput(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout};
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: outputs got %b required %b", name, act, exp);
    end
  endtask

  task automatic checkCounters(input string name, input logic [31:0] expStall, input logic [31:0] expFlush);
    nCompared++;
    if (stall_cycles !== expStall || flush_count !== expFlush) begin
      nMismatched++;
      $display("[TB] FAIL %s: stall_cycles/flush_count got %0d/%0d required %0d/%0d",
               name, stall_cycles, flush_count, expStall, expFlush);
    end
  endtask

  // Advance the model across the coming clock edge, then step the clock.
  task automatic endCycle();
    logic [5:0] o;
    o = modelOut();
    if (rst) begin
      halted = 1'b0; busyStreak = 0; mStall = '0; mFlush = '0;
    end else begin
`ifdef HAZARD_PERF_CNT_EN
      if (!o[5]) mStall = mStall + 32'd1;
      if (o[3])  mFlush = mFlush + 32'd1;
`endif
      if (!halted) begin
        if (dmem_busy) begin
          busyStreak++;
          if (busyStreak > MAX) halted = 1'b1;
        end else begin
          busyStreak = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic simpleCycle(input string name, input logic r, input logic mread, input logic [4:0] rd,
                             input logic br, input logic busy, input logic [5:0] exp);
    applyStimulus(mkVec(name, r, 5'd5, 5'd6, 1'b1, mread, rd, br, busy, exp));
    #2;
    checkOutput(name, exp);
    endCycle();
  endtask

  function automatic logic [4:0] pickReg();
    case ($urandom_range(0, 3))
      0:       return 5'd5;
      1:       return 5'd6;
      2:       return 5'd7;
      default: return 5'd31;
    endcase
  endfunction

  initial begin
    vec_t v;
    logic [31:0] expS, expF;

    table_q.push_back(mkVec("reset",        1, 0, 0, 0, 0, 0,  0, 0, O_RST));
    table_q.push_back(mkVec("idle",         0, 1, 2, 1, 0, 3,  0, 0, O_RUN));
    table_q.push_back(mkVec("lu_rs1",       0, 5, 2, 0, 1, 5,  0, 0, O_LU));
    table_q.push_back(mkVec("lu_release",   0, 5, 2, 0, 0, 5,  0, 0, O_RUN));
    table_q.push_back(mkVec("xzr_no_lu",    0, 31, 2, 1, 1, 31, 0, 0, O_RUN));
    table_q.push_back(mkVec("rs2_unused",   0, 1, 7, 0, 1, 7,  0, 0, O_RUN));
    table_q.push_back(mkVec("lu_rs2",       0, 1, 7, 1, 1, 7,  0, 0, O_LU));
    table_q.push_back(mkVec("br_over_lu",   0, 5, 2, 0, 1, 5,  1, 0, O_BR));
    table_q.push_back(mkVec("busy_br_1",    0, 1, 2, 0, 0, 3,  1, 1, O_FRZ));
    table_q.push_back(mkVec("busy_br_2",    0, 1, 2, 0, 0, 3,  1, 1, O_FRZ));
    table_q.push_back(mkVec("busy_br_3",    0, 1, 2, 0, 0, 3,  1, 1, O_FRZ));
    table_q.push_back(mkVec("br_release",   0, 1, 2, 0, 0, 3,  1, 0, O_BR));
    table_q.push_back(mkVec("after_br",     0, 1, 2, 0, 0, 3,  0, 0, O_RUN));
    table_q.push_back(mkVec("busy_lu",      0, 5, 2, 0, 1, 5,  0, 1, O_FRZ));
    table_q.push_back(mkVec("lu_release2",  0, 5, 2, 0, 1, 5,  0, 0, O_LU));
    table_q.push_back(mkVec("idle2",        0, 1, 2, 0, 0, 3,  0, 0, O_RUN));

    for (int i = 0; i < table_q.size(); i++) begin
      v = table_q[i];
      applyStimulus(v);
      #2;
      checkOutput(v.name, v.exp);
      endCycle();
    end

    // Exactly MAX busy cycles recover cleanly.
    for (int i = 0; i < MAX; i++) simpleCycle("wd_ok_busy", 0, 0, 3, 0, 1, O_FRZ);
    simpleCycle("wd_ok_release", 0, 0, 3, 0, 0, O_RUN);
    simpleCycle("wd_ok_idle", 0, 0, 3, 0, 0, O_RUN);

    // MAX+1 busy cycles trip the sticky timeout.
    for (int i = 0; i < MAX + 1; i++) simpleCycle("wd_trip_busy", 0, 0, 3, 0, 1, O_FRZ);
    simpleCycle("wd_halt_a", 0, 0, 3, 0, 0, O_HALT);
    simpleCycle("wd_halt_b", 0, 0, 3, 1, 1, O_HALT);
    simpleCycle("wd_halt_c", 0, 0, 3, 0, 0, O_HALT);
    simpleCycle("wd_rst", 1, 0, 3, 0, 0, O_RST);
    simpleCycle("wd_after_rst", 0, 0, 3, 0, 0, O_RUN);

    // Perf counters: two load-use stalls and one branch flush.
    simpleCycle("perf_rst", 1, 0, 3, 0, 0, O_RST);
    simpleCycle("perf_lu1", 0, 1, 5, 0, 0, O_LU);
    simpleCycle("perf_idle1", 0, 0, 5, 0, 0, O_RUN);
    simpleCycle("perf_lu2", 0, 1, 5, 0, 0, O_LU);
    simpleCycle("perf_idle2", 0, 0, 5, 0, 0, O_RUN);
    simpleCycle("perf_br", 0, 0, 5, 1, 0, O_BR);
    applyStimulus(mkVec("perf_chk", 0, 5'd5, 5'd6, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, O_RUN));
    #2;
`ifdef HAZARD_PERF_CNT_EN
    expS = 32'd2; expF = 32'd1;
`else
    expS = 32'd0; expF = 32'd0;
`endif
    checkCounters("perf_totals", expS, expF);
    checkOutput("perf_chk", O_RUN);
    endCycle();

    // Random traffic with sticky busy bursts long enough to hit the watchdog sometimes.
    simpleCycle("rand_rst", 1, 0, 3, 0, 0, O_RST);
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 59) == 0);
      id_rs1      = pickReg();
      id_rs2      = pickReg();
      id_uses_rs2 = $urandom_range(0, 1) == 1;
      ex_mem_read = $urandom_range(0, 2) != 0;
      ex_rd       = pickReg();
      br_taken_ex = $urandom_range(0, 4) == 0;
      dmem_busy   = dmem_busy ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 4) == 0);
      #2;
      checkOutput("rand_outputs", modelOut());
      checkCounters("rand_counters", mStall, mFlush);
      endCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the enable and flush of the IF/ID register, the PC-write enable, the ID/EX bubble insert, and a global freeze for data-memory waits.
- Detects load-use hazards and taken branches resolved in EX, and sequences multi-cycle data-memory stalls with a watchdog.
- Sits between hazard sources (ID decode fields, EX stage, dmem) and all pipeline registers.

Parameters:
REG_W, 5, register-index width
MEM_WAIT_MAX, 15, max consecutive dmem_busy cycles before timeout; range 1..255
CNT_W, 32, perf counter width (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
id_rs1  in  REG_W  first source register of instruction in IF/ID
id_rs2  in  REG_W  second source register of instruction in IF/ID
id_uses_rs2  in  1  ID instruction reads id_rs2
ex_mem_read  in  1  instruction in ID/EX is a load
ex_rd  in  REG_W  destination register of ID/EX instruction
br_taken_ex  in  1  branch in EX resolved taken (PC target valid)
dmem_busy  in  1  data memory not ready this cycle
pc_en  out  1  PC register write enable
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  load NOP into IF/ID
id_ex_bubble  out  1  zero control bits into ID/EX
pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
mem_timeout  out  1  sticky watchdog error
stall_cycles  out  CNT_W  perf: cycles with pc_en=0
flush_count  out  CNT_W  perf: taken-branch flushes

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT. State register updates on the clk rising edge.
- Outputs are combinational from the current state and inputs.
- While rst=1:
  - Next state is RUN; the wait counter is cleared; mem_timeout is cleared.
  - Outputs: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1, pipe_freeze=0.
- Reset mid-stall (in any state) returns the block to RUN on the next edge.
- Load-use hazard (lu) = ex_mem_read & ex_rd!=31 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)). X31 (XZR) never hazards.
- RUN, priority order:
  1. dmem_busy=1: freeze. pc_en=0, if_id_en=0, pipe_freeze=1, no flush, no bubble. Next state MEM_WAIT; wait counter loads 1.
  2. else br_taken_ex=1: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_bubble=1. Stay in RUN. A branch overrides lu because the younger instruction is wrong-path.
  3. else lu=1: pc_en=0, if_id_en=0, id_ex_bubble=1. Stay in RUN. Exactly 1 stall cycle, since the load advances to MEM and lu deasserts.
  4. else: pc_en=1, if_id_en=1, others 0.
- MEM_WAIT:
  - Same outputs as RUN case 1 while dmem_busy=1; the counter increments.
  - Counter==MEM_WAIT_MAX with dmem_busy=1: next state HALT.
  - dmem_busy=0: outputs evaluated exactly as in RUN (cases 2-4) in that same cycle; next state RUN. No dead cycle.
  - A branch or load frozen in EX keeps its inputs asserted and is serviced on release.
- HALT: all enables 0, pipe_freeze=1, mem_timeout=1. Held until rst.
- Boundary: dmem_busy for exactly MEM_WAIT_MAX cycles total does not time out; MEM_WAIT_MAX+1 does.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments every non-reset cycle with pc_en=0.
  - flush_count increments every cycle with if_id_flush=1 outside reset.
  - Both clear on rst and wrap modulo 2^CNT_W.
- Undefined: both ports tied to 0 and no counter flops are synthesised.

Decomposition:
- hazard_pkg:
  - state enum hz_state_t {RUN, MEM_WAIT, HALT}
  - XZR_IDX = 31
  - default widths
- Sub-module hazard_lu_detect: purely combinational lu compare. Reusable by a future forwarding unit.
- FSM, watchdog and counters stay in pipe_hazard_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_bubble=1 that cycle; next cycle (ex_mem_read=0) -> pc_en=1.
- XZR / rs2 gating: ex_rd=31=id_rs1 -> no stall. Also ex_rd=7=id_rs2 with id_uses_rs2=0 -> no stall.
- Branch vs load-use same cycle: br_taken_ex=1 plus lu=1 -> pc_en=1, if_id_flush=1, id_ex_bubble=1.
- dmem_busy for 3 cycles with br_taken_ex held -> pipe_freeze=1 for 3 cycles; 4th cycle -> if_id_flush=1, pc_en=1, state RUN.
- Watchdog with MEM_WAIT_MAX=4:
  - busy 4 cycles -> recovers.
  - busy 5 cycles -> mem_timeout=1, sticky until rst pulse.
  - After rst: state RUN, outputs at reset values.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls plus 1 branch -> stall_cycles=2, flush_count=1. Without the macro -> both read 0.
